// File: rtl/aes_round_sched.sv
// Sequencer for an iterative AES-128/192/256 round unit: LOAD, Nr rounds of
// ROUND_CYCLES cycles each, then HOLD until the SPI send logic takes the result.
module aes_round_sched #(
    parameter int ROUND_CYCLES = 1,
    parameter int IDX_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       key_len,
    input  logic             abort,
    input  logic             out_ready,
    output logic             busy,
    output logic             rnd_load,
    output logic             rnd_en,
    output logic [IDX_W-1:0] rnd_idx,
    output logic             rnd_last,
    output logic [IDX_W-1:0] nr,
    output logic             out_valid,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, HOLD} state_t;

    localparam logic [3:0] CYC_LAST = 4'(ROUND_CYCLES - 1);

    state_t           state, state_nx;
    logic [3:0]       cyc, cyc_nx;
    logic [IDX_W-1:0] idx_nx, nr_nx;
    logic             err_nx;

    function automatic logic key_legal(input logic [7:0] k);
        return (k == 8'd16) || (k == 8'd24) || (k == 8'd32);
    endfunction

    function automatic logic [IDX_W-1:0] rounds_for(input logic [7:0] k);
        logic [IDX_W-1:0] r;
        case (k)
            8'd24:   r = IDX_W'(12);
            8'd32:   r = IDX_W'(14);
            default: r = IDX_W'(10);
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cyc     <= '0;
            rnd_idx <= '0;
            nr      <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            cyc     <= cyc_nx;
            rnd_idx <= idx_nx;
            nr      <= nr_nx;
            err     <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        idx_nx   = rnd_idx;
        nr_nx    = nr;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                // abort outranks start, so a simultaneous pair neither launches nor flags err
                if (start && !abort) begin
                    if (key_legal(key_len)) begin
                        state_nx = LOAD;
                        nr_nx    = rounds_for(key_len);
                        idx_nx   = '0;
                        cyc_nx   = '0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            LOAD: begin
                cyc_nx = '0;
                if (abort) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    state_nx = ROUND;
                    idx_nx   = IDX_W'(1);
                end
            end
            ROUND: begin
                if (abort) begin
                    state_nx = IDLE;
                    cyc_nx   = '0;
                    idx_nx   = '0;
                end else if (cyc == CYC_LAST) begin
                    cyc_nx = '0;
                    if (rnd_idx == nr) state_nx = HOLD;
                    else               idx_nx   = rnd_idx + IDX_W'(1);
                end else begin
                    cyc_nx = cyc + 4'd1;
                end
            end
            HOLD: begin
                if (abort || out_ready) begin
                    state_nx = IDLE;
                    cyc_nx   = '0;
                    idx_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cyc_nx   = '0;
                idx_nx   = '0;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign rnd_load  = (state == LOAD);
    assign rnd_en    = (state == ROUND) && (cyc == CYC_LAST);
    assign rnd_last  = (state == ROUND) && (rnd_idx == nr);
    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: one instance with ROUND_CYCLES=1, one with 3.
module tb_aes_round_sched;

    logic       clk = 1'b0;
    logic       reset;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    logic       start1, abort1, ready1;
    logic [7:0] key1;
    logic       busy1, rnd_load1, rnd_en1, rnd_last1, out_valid1, err1;
    logic [3:0] rnd_idx1, nr1;

    logic       start3, abort3, ready3;
    logic [7:0] key3;
    logic       busy3, rnd_load3, rnd_en3, rnd_last3, out_valid3, err3;
    logic [3:0] rnd_idx3, nr3;

    always #5 clk = ~clk;

    aes_round_sched #(.ROUND_CYCLES(1), .IDX_W(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .key_len(key1), .abort(abort1),
        .out_ready(ready1), .busy(busy1), .rnd_load(rnd_load1), .rnd_en(rnd_en1),
        .rnd_idx(rnd_idx1), .rnd_last(rnd_last1), .nr(nr1), .out_valid(out_valid1),
        .err(err1)
    );

    aes_round_sched #(.ROUND_CYCLES(3), .IDX_W(4)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .key_len(key3), .abort(abort3),
        .out_ready(ready3), .busy(busy3), .rnd_load(rnd_load3), .rnd_en(rnd_en3),
        .rnd_idx(rnd_idx3), .rnd_last(rnd_last3), .nr(nr3), .out_valid(out_valid3),
        .err(err3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one block on the ROUND_CYCLES=1 instance with out_ready high.
    task automatic run_block1(input logic [7:0] k, input int exp_nr);
        int loads, ens, valids, overlap, lasts, done_at;
        loads = 0; ens = 0; valids = 0; overlap = 0; lasts = 0; done_at = -1;
        start1 = 1'b1; key1 = k;
        tick;
        start1 = 1'b0;
        total_cnt++;
        if (rnd_load1 !== 1'b1 || rnd_idx1 !== 4'd0)
            $display("FAIL blk_load k=%0d: rnd_load=%b rnd_idx=%0d, want 1/0", k, rnd_load1, rnd_idx1);
        else pass_cnt++;
        for (int off = 0; off < 200; off++) begin
            if (busy1 === 1'b0) begin
                done_at = off;
                break;
            end
            loads  += int'(rnd_load1);
            ens    += int'(rnd_en1);
            valids += int'(out_valid1);
            lasts  += int'(rnd_last1);
            if (rnd_en1 && rnd_load1) overlap++;
            tick;
        end
        total_cnt++;
        if (done_at != exp_nr + 2)
            $display("FAIL blk_len k=%0d: idle after %0d edges, want %0d", k, done_at, exp_nr + 2);
        else pass_cnt++;
        total_cnt++;
        if (loads != 1 || ens != exp_nr || valids != 1 || lasts != 1 || overlap != 0)
            $display("FAIL blk_counts k=%0d: load=%0d en=%0d valid=%0d last=%0d overlap=%0d, want 1/%0d/1/1/0",
                     k, loads, ens, valids, lasts, overlap, exp_nr);
        else pass_cnt++;
        total_cnt++;
        if (nr1 !== 4'(exp_nr))
            $display("FAIL blk_nr k=%0d: nr=%0d, want %0d", k, nr1, exp_nr);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if ({busy1, rnd_load1, rnd_en1, rnd_idx1, rnd_last1, nr1, out_valid1, err1} !== 14'd0)
            $display("FAIL reset_dut1: outputs=%h, want 0",
                     {busy1, rnd_load1, rnd_en1, rnd_idx1, rnd_last1, nr1, out_valid1, err1});
        else pass_cnt++;
        total_cnt++;
        if ({busy3, rnd_load3, rnd_en3, rnd_idx3, rnd_last3, nr3, out_valid3, err3} !== 14'd0)
            $display("FAIL reset_dut3: outputs=%h, want 0",
                     {busy3, rnd_load3, rnd_en3, rnd_idx3, rnd_last3, nr3, out_valid3, err3});
        else pass_cnt++;
        #10 reset = 1'b1;
        tick;
    endtask

    task automatic test_basic_rc1;
        int bad;
        bad = 0;
        start1 = 1'b1; key1 = 8'd16;
        tick;
        start1 = 1'b0;
        total_cnt++;
        if (rnd_load1 !== 1'b1 || rnd_idx1 !== 4'd0 || busy1 !== 1'b1 || rnd_en1 !== 1'b0)
            $display("FAIL basic_load: load=%b idx=%0d busy=%b en=%b, want 1/0/1/0",
                     rnd_load1, rnd_idx1, busy1, rnd_en1);
        else pass_cnt++;
        for (int off = 1; off <= 10; off++) begin
            tick;
            if (rnd_en1 !== 1'b1 || rnd_idx1 !== 4'(off) || rnd_last1 !== (off == 10) || rnd_load1 !== 1'b0)
                bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL basic_rounds: %0d bad round cycles, want 0", bad);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (out_valid1 !== 1'b1 || rnd_en1 !== 1'b0 || rnd_idx1 !== 4'd10 || rnd_last1 !== 1'b0)
            $display("FAIL basic_hold: valid=%b en=%b idx=%0d last=%b, want 1/0/10/0",
                     out_valid1, rnd_en1, rnd_idx1, rnd_last1);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (busy1 !== 1'b0 || out_valid1 !== 1'b0)
            $display("FAIL basic_done: busy=%b valid=%b, want 0/0", busy1, out_valid1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_round;
        bit found;
        found = 1'b0;
        start1 = 1'b1; key1 = 8'd24;
        tick;
        start1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rnd_idx1 === 4'd5) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        total_cnt++;
        if (!found) $display("FAIL midrst_reach: rnd_idx=%0d never reached 5", rnd_idx1);
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++;
        if ({busy1, rnd_load1, rnd_en1, rnd_idx1, rnd_last1, nr1, out_valid1, err1} !== 14'd0)
            $display("FAIL midrst_async: outputs=%h, want 0",
                     {busy1, rnd_load1, rnd_en1, rnd_idx1, rnd_last1, nr1, out_valid1, err1});
        else pass_cnt++;
        #2 reset = 1'b1;
        tick;
        total_cnt++;
        if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || rnd_idx1 !== 4'd0)
            $display("FAIL midrst_idle: busy=%b valid=%b idx=%0d, want 0/0/0", busy1, out_valid1, rnd_idx1);
        else pass_cnt++;
        run_block1(8'd16, 10);
    endtask

    task automatic test_rc3;
        int ens, bad, rise, bad_hold;
        ens = 0; bad = 0; rise = -1; bad_hold = 0;
        ready3 = 1'b0;
        start3 = 1'b1; key3 = 8'd32;
        tick;
        start3 = 1'b0;
        for (int off = 0; off < 100; off++) begin
            if (rnd_en3 === 1'b1) begin
                ens++;
                if (off != 3 * ens) bad++;
            end
            if (out_valid3 === 1'b1) begin
                rise = off;
                break;
            end
            tick;
        end
        total_cnt++;
        if (ens != 14 || bad != 0)
            $display("FAIL rc3_rounds: en=%0d misplaced=%0d, want 14/0", ens, bad);
        else pass_cnt++;
        total_cnt++;
        if (rise != 43) $display("FAIL rc3_latency: out_valid after %0d edges, want 43", rise);
        else pass_cnt++;
        total_cnt++;
        if (rnd_idx3 !== 4'd14 || nr3 !== 4'd14)
            $display("FAIL rc3_hold_idx: idx=%0d nr=%0d, want 14/14", rnd_idx3, nr3);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            start3 = (i == 5 || i == 12);
            key3   = 8'd16;
            tick;
            if (out_valid3 !== 1'b1 || nr3 !== 4'd14 || rnd_idx3 !== 4'd14 || rnd_en3 !== 1'b0 || rnd_load3 !== 1'b0)
                bad_hold++;
        end
        start3 = 1'b0;
        total_cnt++;
        if (bad_hold != 0) $display("FAIL rc3_hold: %0d bad HOLD cycles, want 0", bad_hold);
        else pass_cnt++;
        ready3 = 1'b1;
        tick;
        total_cnt++;
        if (out_valid3 !== 1'b0 || busy3 !== 1'b0)
            $display("FAIL rc3_accept: valid=%b busy=%b, want 0/0", out_valid3, busy3);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (busy3 !== 1'b0 || rnd_load3 !== 1'b0)
            $display("FAIL rc3_no_restart: busy=%b load=%b, want 0/0", busy3, rnd_load3);
        else pass_cnt++;
    endtask

    task automatic test_err;
        start1 = 1'b1; key1 = 8'd20;
        tick;
        start1 = 1'b0;
        total_cnt++;
        if (err1 !== 1'b1 || busy1 !== 1'b0 || nr1 !== 4'd10)
            $display("FAIL err_pulse: err=%b busy=%b nr=%0d, want 1/0/10", err1, busy1, nr1);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (err1 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL err_clear: err=%b busy=%b, want 0/0", err1, busy1);
        else pass_cnt++;
        run_block1(8'd24, 12);
    endtask

    task automatic test_abort;
        bit found;
        int valids;
        found = 1'b0; valids = 0;
        start1 = 1'b1; key1 = 8'd16;
        tick;
        start1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rnd_idx1 === 4'd7) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        total_cnt++;
        if (!found) $display("FAIL abort_reach: rnd_idx=%0d never reached 7", rnd_idx1);
        else pass_cnt++;
        abort1 = 1'b1;
        tick;
        abort1 = 1'b0;
        total_cnt++;
        if (busy1 !== 1'b0 || rnd_idx1 !== 4'd0 || rnd_en1 !== 1'b0)
            $display("FAIL abort_idle: busy=%b idx=%0d en=%b, want 0/0/0", busy1, rnd_idx1, rnd_en1);
        else pass_cnt++;
        for (int i = 0; i < 15; i++) begin
            valids += int'(out_valid1) + int'(busy1);
            tick;
        end
        total_cnt++;
        if (valids != 0) $display("FAIL abort_quiet: %0d valid/busy cycles after abort, want 0", valids);
        else pass_cnt++;
        run_block1(8'd16, 10);
    endtask

    task automatic test_start_abort;
        abort1 = 1'b1; start1 = 1'b1; key1 = 8'd16;
        tick;
        total_cnt++;
        if (busy1 !== 1'b0 || err1 !== 1'b0)
            $display("FAIL sa_legal: busy=%b err=%b, want 0/0", busy1, err1);
        else pass_cnt++;
        key1 = 8'd5;
        tick;
        total_cnt++;
        if (busy1 !== 1'b0 || err1 !== 1'b0)
            $display("FAIL sa_illegal: busy=%b err=%b, want 0/0", busy1, err1);
        else pass_cnt++;
        abort1 = 1'b0; start1 = 1'b0;
        tick;
        total_cnt++;
        if (busy1 !== 1'b0 || err1 !== 1'b0 || nr1 !== 4'd10)
            $display("FAIL sa_after: busy=%b err=%b nr=%0d, want 0/0/10", busy1, err1, nr1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        run_block1(8'd32, 14);
        run_block1(8'd16, 10);
        run_block1(8'd24, 12);
    endtask

    initial begin
        reset  = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; key1 = 8'd0;
        start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b0; key3 = 8'd0;
        test_reset;
        test_basic_rc1;
        test_reset_mid_round;
        test_rc3;
        test_err;
        test_abort;
        test_start_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
- Sequencing controller for an iterative AES-128/192/256 encryption datapath. One round unit is reused over Nr rounds instead of unrolling Nr rounds in logic.
- Accepts a start request carrying the key-length byte (16/24/32, the same encoding the SPI front end extracts from the received frame).
- Drives the datapath's load, round-enable, round-index and last-round controls.
- Presents the result through a valid/ready handshake to the SPI send logic.

Parameters:
- ROUND_CYCLES, 1, clock cycles the round unit needs per round (legal 1..15); rnd_en fires on the last cycle of each round.
- IDX_W, 4, width of the round index and Nr outputs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to begin one block; sampled only in IDLE.
- key_len  in  8  key size in bytes, sampled with start: 16 gives Nr=10, 24 gives Nr=12, 32 gives Nr=14.
- abort  in  1  synchronous cancel; overrides start and out_ready.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in LOAD, ROUND and HOLD.
- rnd_load  out  1  one-cycle pulse: datapath loads state = plaintext ^ round key 0.
- rnd_en  out  1  one-cycle pulse per round: datapath commits round rnd_idx.
- rnd_idx  out  IDX_W  current round number (0 in LOAD, 1..Nr in ROUND, Nr in HOLD).
- rnd_last  out  1  high while rnd_idx==Nr in ROUND (datapath skips MixColumns).
- nr  out  IDX_W  latched round count for the key schedule.
- out_valid  out  1  result stable on the datapath output.
- err  out  1  one-cycle pulse when start is sampled with an illegal key_len.

Behaviour:
- All outputs are decoded from registered state only; there is no combinational input-to-output path.
- Reset (reset=0, asynchronous) forces state=IDLE and cyc=0, and every output to 0, including rnd_idx and nr.
  - Reset asserted mid-round abandons the block. No out_valid follows.
- States: IDLE, LOAD, ROUND, HOLD.
- IDLE:
  - start=1 with key_len in {16,24,32}: nr latched, next state LOAD.
  - start=1 with any other key_len: err=1 for the following cycle, state stays IDLE, nr unchanged.
  - start=0: remain in IDLE.
- LOAD (exactly 1 cycle): rnd_load=1, rnd_idx=0. Next state ROUND with rnd_idx=1, cyc=0.
- ROUND:
  - cyc counts 0..ROUND_CYCLES-1.
  - rnd_en=1 only when cyc==ROUND_CYCLES-1. On that edge cyc returns to 0.
  - If rnd_idx<nr, rnd_idx increments. If rnd_idx==nr, next state is HOLD.
  - rnd_last=1 for all ROUND cycles with rnd_idx==nr.
- HOLD:
  - out_valid=1, rnd_idx holds at nr.
  - out_ready=1 sampled: next state IDLE, out_valid drops on the same edge.
  - start is ignored in HOLD. A new block needs a start in IDLE, so back-to-back blocks see at least one IDLE cycle.
- abort=1 in any state: next state IDLE, cyc=0, no rnd_en/out_valid/err generated on that edge. abort in IDLE has no effect.
- Latency: out_valid rises 1 + nr*ROUND_CYCLES cycles after the edge that samples start.
  - Example, ROUND_CYCLES=1, key_len=16: rnd_load in cycle 1, rnd_en in cycles 2..11, out_valid from cycle 12.
- Exactly one rnd_load and exactly nr rnd_en pulses per completed block. rnd_en never coincides with rnd_load.
- Simultaneous start and abort in IDLE: abort wins, state stays IDLE, no err.
- out_ready while not in HOLD is ignored.

Test Plan:
- Reset low mid-ROUND (key_len=24, rnd_idx=5) -> all outputs 0 immediately, without waiting for a clock edge. After release, state IDLE; a new start runs normally.
- ROUND_CYCLES=1, start with key_len=16, out_ready=1 -> rnd_load in cycle 1, rnd_idx 1..10 with 10 rnd_en pulses, rnd_last only at idx 10, out_valid for 1 cycle at cycle 12, busy=0 at cycle 13.
- ROUND_CYCLES=3, key_len=32, out_ready held 0 for 20 cycles then 1 -> 14 rnd_en pulses spaced 3 cycles apart. out_valid rises at cycle 43, stays high until the out_ready edge, and start pulses during HOLD are ignored.
- key_len=20 with start -> err pulse for one cycle, busy stays 0, nr unchanged. Then key_len=24 -> nr=12 and 12 rnd_en pulses.
- abort asserted at rnd_idx=7 (key_len=16) -> IDLE next cycle, no out_valid. A following start completes with a fresh rnd_load and rnd_idx restarting at 0.
- start and abort together in IDLE -> no state change, no err. Back-to-back blocks -> each has exactly 1 rnd_load, nr rnd_en and 1 out_valid handshake, with at least one IDLE cycle between them.
